// File: rtl/bullet_pool_ctrl.sv
// Pool of NUM_SLOTS player bullets: per-frame spawn, upward motion, box collision, slot freeing.
// Optional hold-to-fire behaviour is enabled by defining BULLET_POOL_AUTOFIRE_EN.
module bullet_pool_ctrl #(
  parameter int NUM_SLOTS  = 4,
  parameter int COORD_W    = 11,
  parameter int SPEED      = 8,
  parameter int COOLDOWN   = 8,
  parameter int BULLET_W   = 32,
  parameter int BULLET_H   = 64,
  parameter int TGT_W      = 128,
  parameter int TGT_H      = 128,
  localparam int IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 fire,
  input  logic [COORD_W-1:0]   spawn_x,
  input  logic [COORD_W-1:0]   spawn_y,
  input  logic [COORD_W-1:0]   tgt_x,
  input  logic [COORD_W-1:0]   tgt_y,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [COORD_W-1:0]   rd_x,
  output logic [COORD_W-1:0]   rd_y,
  output logic                 rd_valid,
  output logic [NUM_SLOTS-1:0] active_mask,
  output logic                 hit_pulse,
  output logic [15:0]          hit_count,
  output logic                 busy
);

  localparam int EXT_W = COORD_W + 1;
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [COORD_W-1:0] SPEED_C    = COORD_W'(SPEED);
  localparam logic [CD_W-1:0]    COOLDOWN_C = CD_W'(COOLDOWN);
  localparam logic [EXT_W-1:0]   BW_E       = EXT_W'(BULLET_W);
  localparam logic [EXT_W-1:0]   BH_E       = EXT_W'(BULLET_H);
  localparam logic [EXT_W-1:0]   TW_E       = EXT_W'(TGT_W);
  localparam logic [EXT_W-1:0]   TH_E       = EXT_W'(TGT_H);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_SLOTS - 1);
  localparam logic [IDX_W:0]     NSLOT_E    = (IDX_W + 1)'(NUM_SLOTS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SPAWN  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nx_s;
  logic [IDX_W-1:0]     idx_r;
  logic [COORD_W-1:0]   slot_x_r [NUM_SLOTS];
  logic [COORD_W-1:0]   slot_y_r [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] live_r;
  logic [CD_W-1:0]      cooldown_r;
  logic                 fire_prev_r;
  logic                 fire_pend_r;
  logic                 hit_pulse_r;
  logic [15:0]          hit_count_r;
  logic                 busy_r;

  logic                 spawn_en_s;
  logic                 update_en_s;
  logic                 fire_set_s;
  logic                 auto_fire_s;
  logic                 any_free_s;
  logic [IDX_W-1:0]     free_idx_s;
  logic                 alloc_ok_s;
  logic [COORD_W-1:0]   cur_x_s;
  logic [COORD_W-1:0]   cur_y_s;
  logic [COORD_W-1:0]   ynew_s;
  logic                 cur_live_s;
  logic                 exit_s;
  logic                 ovl_x_s;
  logic                 ovl_y_s;
  logic                 hit_s;
  logic                 free_s;

  // Lowest-index free slot; scanning downward leaves the smallest index last.
  function automatic logic [IDX_W-1:0] lowest_free(input logic [NUM_SLOTS-1:0] live);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!live[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

`ifdef BULLET_POOL_AUTOFIRE_EN
  assign auto_fire_s = frame_tick & fire & (state_r == ST_IDLE);
`else
  assign auto_fire_s = 1'b0;
`endif

  // Frame FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Frame FSM next-state logic; ticks arriving mid-sweep are ignored.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_tick) state_nx_s = ST_SPAWN;
        else            state_nx_s = ST_IDLE;
      end
      ST_SPAWN:  state_nx_s = ST_UPDATE;
      ST_UPDATE: begin
        if (idx_r == LAST_IDX) state_nx_s = ST_IDLE;
        else                   state_nx_s = ST_UPDATE;
      end
      default:   state_nx_s = ST_IDLE;
    endcase
  end

  // Frame FSM decoded phase strobes.
  always_comb begin
    spawn_en_s  = 1'b0;
    update_en_s = 1'b0;
    case (state_r)
      ST_SPAWN:  spawn_en_s  = 1'b1;
      ST_UPDATE: update_en_s = 1'b1;
      default: begin
        spawn_en_s  = 1'b0;
        update_en_s = 1'b0;
      end
    endcase
  end

  // Spawn decision and per-slot motion/collision for the slot under the sweep index.
  always_comb begin
    fire_set_s = (fire & ~fire_prev_r) | auto_fire_s;
    any_free_s = ~(&live_r);
    free_idx_s = lowest_free(live_r);
    alloc_ok_s = fire_pend_r & (cooldown_r == {CD_W{1'b0}}) & any_free_s;
    cur_x_s    = slot_x_r[idx_r];
    cur_y_s    = slot_y_r[idx_r];
    cur_live_s = live_r[idx_r];
    exit_s     = (cur_y_s < SPEED_C);
    ynew_s     = cur_y_s - SPEED_C;
    // One extra bit keeps edge sums near the screen limit from wrapping.
    ovl_x_s    = (({1'b0, cur_x_s} + BW_E) > {1'b0, tgt_x}) &&
                 ({1'b0, cur_x_s} < ({1'b0, tgt_x} + TW_E));
    ovl_y_s    = (({1'b0, ynew_s} + BH_E) > {1'b0, tgt_y}) &&
                 ({1'b0, ynew_s} < ({1'b0, tgt_y} + TH_E));
    hit_s      = update_en_s & cur_live_s & ~exit_s & ovl_x_s & ovl_y_s;
    free_s     = update_en_s & cur_live_s & (exit_s | hit_s);
  end

  // Sweep index: cleared on entry to UPDATE, advanced once per visited slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_r <= {IDX_W{1'b0}};
    end else if (spawn_en_s) begin
      idx_r <= {IDX_W{1'b0}};
    end else if (update_en_s && (idx_r != LAST_IDX)) begin
      idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
    end
  end

  // Fire capture: a new request survives until the next SPAWN consumes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fire_prev_r <= 1'b0;
      fire_pend_r <= 1'b0;
    end else begin
      fire_prev_r <= fire;
      if (fire_set_s) begin
        fire_pend_r <= 1'b1;
      end else if (spawn_en_s) begin
        fire_pend_r <= 1'b0;
      end
    end
  end

  // Cooldown: loaded on a successful spawn, otherwise counts down once per frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cooldown_r <= {CD_W{1'b0}};
    end else if (spawn_en_s) begin
      if (alloc_ok_s) begin
        cooldown_r <= COOLDOWN_C;
      end else if (cooldown_r != {CD_W{1'b0}}) begin
        cooldown_r <= cooldown_r - {{(CD_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Slot storage: allocation in SPAWN, motion and freeing in UPDATE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_x_r[i] <= {COORD_W{1'b0}};
        slot_y_r[i] <= {COORD_W{1'b0}};
      end
      live_r <= {NUM_SLOTS{1'b0}};
    end else if (spawn_en_s && alloc_ok_s) begin
      slot_x_r[free_idx_s] <= spawn_x;
      slot_y_r[free_idx_s] <= spawn_y;
      live_r[free_idx_s]   <= 1'b1;
    end else if (update_en_s && cur_live_s) begin
      if (!exit_s) begin
        slot_y_r[idx_r] <= ynew_s;
      end
      if (free_s) begin
        live_r[idx_r] <= 1'b0;
      end
    end
  end

  // Hit reporting: one pulse per collision, saturating total.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_pulse_r <= 1'b0;
      hit_count_r <= 16'h0000;
    end else begin
      hit_pulse_r <= hit_s;
      if (hit_s && (hit_count_r != 16'hFFFF)) begin
        hit_count_r <= hit_count_r + 16'h0001;
      end
    end
  end

  // Busy follows the FSM leaving IDLE and returning to it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_nx_s != ST_IDLE);
    end
  end

  // Indexed readout for the video path; out-of-range indices read as an empty slot.
  always_comb begin
    rd_x     = {COORD_W{1'b0}};
    rd_y     = {COORD_W{1'b0}};
    rd_valid = 1'b0;
    if ({1'b0, rd_idx} < NSLOT_E) begin
      rd_x     = slot_x_r[rd_idx];
      rd_y     = slot_y_r[rd_idx];
      rd_valid = live_r[rd_idx];
    end else begin
      rd_x     = {COORD_W{1'b0}};
      rd_y     = {COORD_W{1'b0}};
      rd_valid = 1'b0;
    end
  end

  assign active_mask = live_r;
  assign hit_pulse   = hit_pulse_r;
  assign hit_count   = hit_count_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Directed bench for bullet_pool_ctrl: single-bullet vector table plus multi-frame sequences.
// Built with the DUT at COOLDOWN=2; expectations follow BULLET_POOL_AUTOFIRE_EN when defined.
module tb_bullet_pool_ctrl;

  localparam int NS = 4;
  localparam int CW = 11;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_tick = 1'b0;
  logic          fire = 1'b0;
  logic [CW-1:0] spawn_x = '0;
  logic [CW-1:0] spawn_y = '0;
  logic [CW-1:0] tgt_x = '0;
  logic [CW-1:0] tgt_y = '0;
  logic [IW-1:0] rd_idx = '0;
  logic [CW-1:0] rd_x;
  logic [CW-1:0] rd_y;
  logic          rd_valid;
  logic [NS-1:0] active_mask;
  logic          hit_pulse;
  logic [15:0]   hit_count;
  logic          busy;

  int total = 0;
  int bad   = 0;

  bullet_pool_ctrl #(.NUM_SLOTS(NS), .COORD_W(CW), .SPEED(8), .COOLDOWN(2),
                     .BULLET_W(32), .BULLET_H(64), .TGT_W(128), .TGT_H(128)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .fire(fire),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .tgt_x(tgt_x), .tgt_y(tgt_y),
    .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid),
    .active_mask(active_mask), .hit_pulse(hit_pulse), .hit_count(hit_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] sx;
    logic [CW-1:0] sy;
    logic [CW-1:0] tx;
    logic [CW-1:0] ty;
    int            hits;
    logic          valid;
    logic [CW-1:0] y;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic press();
    fire = 1'b1;
    @(negedge clk);
    fire = 1'b0;
    @(negedge clk);
  endtask

  // Issue one frame tick and follow the sweep until busy drops (bounded).
  task automatic run_frame(output int hits, output int busy_cyc);
    hits = 0;
    busy_cyc = 0;
    frame_tick = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      if (hit_pulse) hits++;
      if (busy) busy_cyc++;
      else break;
    end
    check("sweep_done", {31'd0, busy}, 32'd0);
  endtask

  int h;
  int bc;
  int exp_n;
  logic [CW-1:0] exp_y4 [4];

  initial begin
    vecs[0]  = '{11'd100,  11'd600,  11'd1800, 11'd0,   0, 1'b1, 11'd592};
    vecs[1]  = '{11'd200,  11'd300,  11'd180,  11'd200, 1, 1'b0, 11'd292};
    vecs[2]  = '{11'd100,  11'd5,    11'd1800, 11'd0,   0, 1'b0, 11'd5};
    vecs[3]  = '{11'd100,  11'd8,    11'd1800, 11'd0,   0, 1'b1, 11'd0};
    vecs[4]  = '{11'd100,  11'd7,    11'd1800, 11'd0,   0, 1'b0, 11'd7};
    vecs[5]  = '{11'd148,  11'd300,  11'd180,  11'd200, 0, 1'b1, 11'd292};
    vecs[6]  = '{11'd149,  11'd300,  11'd180,  11'd200, 1, 1'b0, 11'd292};
    vecs[7]  = '{11'd308,  11'd300,  11'd180,  11'd200, 0, 1'b1, 11'd292};
    vecs[8]  = '{11'd307,  11'd300,  11'd180,  11'd200, 1, 1'b0, 11'd292};
    vecs[9]  = '{11'd200,  11'd144,  11'd180,  11'd200, 0, 1'b1, 11'd136};
    vecs[10] = '{11'd200,  11'd145,  11'd180,  11'd200, 1, 1'b0, 11'd137};
    vecs[11] = '{11'd200,  11'd336,  11'd180,  11'd200, 0, 1'b1, 11'd328};
    vecs[12] = '{11'd200,  11'd335,  11'd180,  11'd200, 1, 1'b0, 11'd327};
    vecs[13] = '{11'd2040, 11'd1000, 11'd2000, 11'd900, 1, 1'b0, 11'd992};
    vecs[14] = '{11'd10,   11'd1000, 11'd2000, 11'd900, 0, 1'b1, 11'd992};

    // Reset state
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mask", {28'd0, active_mask}, 32'd0);
    check("rst_hit_count", {16'd0, hit_count}, 32'd0);
    check("rst_hit_pulse", {31'd0, hit_pulse}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single-bullet table: one press, one frame, then inspect slot 0
    for (int v = 0; v < 15; v++) begin
      do_reset();
      spawn_x = vecs[v].sx; spawn_y = vecs[v].sy;
      tgt_x = vecs[v].tx;   tgt_y = vecs[v].ty;
      rd_idx = 2'd0;
      press();
      run_frame(h, bc);
      #1;
      check($sformatf("v%0d_hits", v), h, vecs[v].hits);
      check($sformatf("v%0d_busy_cycles", v), bc, 32'd5);
      check($sformatf("v%0d_hit_count", v), {16'd0, hit_count}, vecs[v].hits);
      check($sformatf("v%0d_valid", v), {31'd0, rd_valid}, {31'd0, vecs[v].valid});
      check($sformatf("v%0d_y", v), {21'd0, rd_y}, {21'd0, vecs[v].y});
      check($sformatf("v%0d_x", v), {21'd0, rd_x}, {21'd0, vecs[v].sx});
      check($sformatf("v%0d_mask", v), {28'd0, active_mask}, {31'd0, vecs[v].valid});
    end

    // Asynchronous reset in the middle of a sweep
    do_reset();
    spawn_x = 11'd100; spawn_y = 11'd600; tgt_x = 11'd1800; tgt_y = 11'd0; rd_idx = 2'd0;
    press();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    check("mid_mask", {28'd0, active_mask}, 32'd1);
    rst = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_mask", {28'd0, active_mask}, 32'd0);
    check("arst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("arst_rd_y", {21'd0, rd_y}, 32'd0);
    check("arst_rd_x", {21'd0, rd_x}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("arst_idle_after", {31'd0, busy}, 32'd0);

    // Full pool: presses on frames 1,4,7,10,13 (cooldown 2); fifth is dropped
    do_reset();
    tgt_x = 11'd1800; tgt_y = 11'd0; spawn_y = 11'd1000;
    for (int f = 1; f <= 13; f++) begin
      if ((f % 3) == 1) begin
        spawn_x = 11'(100 + 10 * ((f - 1) / 3));
        press();
      end
      run_frame(h, bc);
    end
    check("full_mask", {28'd0, active_mask}, 32'hF);
    exp_y4[0] = 11'd896; exp_y4[1] = 11'd920; exp_y4[2] = 11'd944; exp_y4[3] = 11'd968;
    for (int i = 0; i < 4; i++) begin
      rd_idx = IW'(i);
      #1;
      check($sformatf("full_x%0d", i), {21'd0, rd_x}, 32'(100 + 10 * i));
      check($sformatf("full_y%0d", i), {21'd0, rd_y}, {21'd0, exp_y4[i]});
    end
    @(negedge clk);

    // Two live bullets hit in the same sweep
    do_reset();
    tgt_x = 11'd1800; tgt_y = 11'd0; spawn_x = 11'd200; spawn_y = 11'd600;
    press();
    run_frame(h, bc);
    run_frame(h, bc);
    run_frame(h, bc);
    spawn_y = 11'd640;
    press();
    run_frame(h, bc);
    check("multi_pre_mask", {28'd0, active_mask}, 32'h3);
    tgt_x = 11'd180; tgt_y = 11'd500;
    run_frame(h, bc);
    check("multi_hits", h, 32'd2);
    check("multi_hit_count", {16'd0, hit_count}, 32'd2);
    check("multi_mask", {28'd0, active_mask}, 32'd0);

    // Top exit then reuse of the slot once cooldown has expired
    do_reset();
    tgt_x = 11'd1800; tgt_y = 11'd0; spawn_x = 11'd100; spawn_y = 11'd5; rd_idx = 2'd0;
    press();
    run_frame(h, bc);
    check("exit_mask", {28'd0, active_mask}, 32'd0);
    run_frame(h, bc);
    run_frame(h, bc);
    spawn_y = 11'd500;
    press();
    run_frame(h, bc);
    #1;
    check("reuse_mask", {28'd0, active_mask}, 32'd1);
    check("reuse_y", {21'd0, rd_y}, 32'd492);

    // Saturation of the hit counter from a preloaded maximum
    do_reset();
    force dut.hit_count_r = 16'hFFFF;
    @(negedge clk);
    release dut.hit_count_r;
    @(negedge clk);
    check("sat_preload", {16'd0, hit_count}, 32'h0000FFFF);
    spawn_x = 11'd200; spawn_y = 11'd300; tgt_x = 11'd180; tgt_y = 11'd200;
    press();
    run_frame(h, bc);
    check("sat_hits", h, 32'd1);
    check("sat_hit_count", {16'd0, hit_count}, 32'h0000FFFF);

    // Fire held for ten frames with cooldown 2
    do_reset();
    tgt_x = 11'd1800; tgt_y = 11'd0; spawn_x = 11'd100; spawn_y = 11'd1000;
    fire = 1'b1;
    for (int f = 1; f <= 10; f++) begin
      run_frame(h, bc);
`ifdef BULLET_POOL_AUTOFIRE_EN
      exp_n = (f < 4) ? 1 : (f < 7) ? 2 : (f < 10) ? 3 : 4;
`else
      exp_n = 1;
`endif
      check($sformatf("hold_f%0d", f), $countones(active_mask), exp_n);
    end
    fire = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
